// File: rtl/otp_stream_decoder_pkg.sv
// Shared definitions for the byte-serial one-time-pad decoder: byte width,
// default key size, FSM state encoding and the buffered output beat layout.
package otp_stream_decoder_pkg;

  localparam int BYTE_W           = 8;
  localparam int KEY_SIZE_DEFAULT = 16;
  localparam int FIFO_DEPTH       = 2;

  // Decoder control states (2-bit encoding)
  typedef enum logic [1:0] {
    ST_NO_KEY = 2'd0,
    ST_IDLE   = 2'd1,
    ST_FRAME  = 2'd2
  } state_e;

  // One plaintext beat as held in the output buffer
  typedef struct packed {
    logic              last;
    logic [BYTE_W-1:0] data;
  } beat_t;

  // Width of the key byte index; a single-byte key still needs one bit
  function automatic int idx_width(input int key_bytes);
    return (key_bytes > 1) ? $clog2(key_bytes) : 1;
  endfunction

endpackage

// File: rtl/otp_stream_decoder_out_fifo.sv
// Two-entry synchronous FIFO holding plaintext beats (data + last).
// A push while full or a pop while empty is ignored. The read port shows
// all zeros while the FIFO is empty so downstream data is clean when idle.
module otp_out_fifo
  import otp_stream_decoder_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  beat_t wr_beat,
  input  logic  pop,
  output beat_t rd_beat,
  output logic  full,
  output logic  empty
);

  localparam logic [1:0] FULL_CNT = 2'(FIFO_DEPTH);

  beat_t       mem_q [FIFO_DEPTH];
  beat_t       mem_d [FIFO_DEPTH];
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  count_q, count_d;
  logic        do_push;
  logic        do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == 2'd0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_beat = empty ? '0 : mem_q[rd_ptr_q];

  // Next storage, pointers and occupancy; simultaneous push/pop keeps count
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wr_beat;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Storage and pointer registers; reset empties the buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/otp_stream_decoder.sv
// Byte-serial one-time-pad decryptor. Ciphertext bytes arrive on the s_*
// stream, are XORed with a repeating KEY_SIZE-bit key (byte 0 is the most
// significant key byte) and leave on the m_* stream through a 2-entry buffer.
// The key index restarts at byte 0 for every frame.
//
// Handshake: on both streams a beat transfers on a rising clock edge where
// valid and ready are both 1. A source holds valid, data and last stable
// until the transfer. s_ready is a function of registered state only and
// never looks at s_valid; m_valid/m_data/m_last come straight from the
// buffer head, so they hold while m_ready is low and read zero when empty.
module otp_stream_decoder
  import otp_stream_decoder_pkg::*;
#(
  parameter int KEY_SIZE = KEY_SIZE_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                key_load,
  input  logic [KEY_SIZE-1:0] key_in,
  output logic                key_err,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [BYTE_W-1:0]   s_data,
  input  logic                s_last,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [BYTE_W-1:0]   m_data,
  output logic                m_last,
  output logic                busy
);

  localparam int                KEY_BYTES = KEY_SIZE / BYTE_W;
  localparam int                IDX_W     = idx_width(KEY_BYTES);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(KEY_BYTES - 1);

  state_e              state_q, state_d;
  logic [KEY_SIZE-1:0] key_q, key_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                key_err_q, key_err_d;

  logic [BYTE_W-1:0]   key_bytes [KEY_BYTES];
  logic                accept;
  logic                fifo_full;
  logic                fifo_empty;
  beat_t               wr_beat;
  beat_t               rd_beat;

  // Split the key register into bytes, most significant byte first
  for (genvar g = 0; g < KEY_BYTES; g++) begin : g_key_bytes
    assign key_bytes[g] = key_q[KEY_SIZE-1-BYTE_W*g -: BYTE_W];
  end

  assign s_ready = (state_q != ST_NO_KEY) && !fifo_full;
  assign accept  = s_valid && s_ready;

  // The current byte always uses the registered key, so a key load in the
  // same cycle as an accepted byte only affects the following bytes.
  always_comb begin
    wr_beat      = '0;
    wr_beat.data = s_data ^ key_bytes[idx_q];
    wr_beat.last = s_last;
  end

  // Next-state, key register, key index and reject pulse
  always_comb begin
    state_d   = state_q;
    key_d     = key_q;
    idx_d     = idx_q;
    key_err_d = 1'b0;

    if (accept) begin
      if (s_last || (idx_q == IDX_LAST)) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end

    case (state_q)
      ST_NO_KEY: begin
        if (key_load) begin
          key_d   = key_in;
          idx_d   = '0;
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (accept && !s_last) begin
          state_d = ST_FRAME;
        end
        if (key_load) begin
          key_d = key_in;
          idx_d = '0;
        end
      end
      ST_FRAME: begin
        if (accept && s_last) begin
          state_d = ST_IDLE;
        end
        // Changing the pad mid-frame would corrupt the frame; refuse it
        if (key_load) begin
          key_err_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_NO_KEY;
      end
    endcase
  end

  // Control and key registers; reset forgets the key entirely
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_NO_KEY;
      key_q     <= '0;
      idx_q     <= '0;
      key_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      key_q     <= key_d;
      idx_q     <= idx_d;
      key_err_q <= key_err_d;
    end
  end

  otp_out_fifo u_out_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (accept),
    .wr_beat (wr_beat),
    .pop     (m_ready),
    .rd_beat (rd_beat),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign m_valid = !fifo_empty;
  assign m_data  = rd_beat.data;
  assign m_last  = rd_beat.last;
  assign key_err = key_err_q;
  assign busy    = (state_q == ST_FRAME) || !fifo_empty;

endmodule
